// File: rtl/seq_detect_sched_pkg.sv
// Shared definitions for the sequence-detector scheduler: FSM states,
// width helpers and default parameter values.
package seq_detect_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int LEN_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    TAIL,
    RESP
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a hit counter that must hold values 0..len.
  function automatic int hitw(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_sched_core.sv
// Two-bit T-flip-flop sequence-detector core. Output is high when both
// state bits are set. Synchronous clear outranks enable; with neither
// asserted the state holds.
module seq_detect_core (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic out
);

  logic a;
  logic b;

  // State bits: async reset, then clear, then a T-flip-flop step on enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= 1'b0;
      b <= 1'b0;
    end else if (clr) begin
      a <= 1'b0;
      b <= 1'b0;
    end else if (en) begin
      b <= b ^ din;
      a <= a ^ ((b & din) | (a & b));
    end
  end

  assign out = a & b;

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that time-shares one sequence-detector core among
// NREQ requesters. Each job clears the core, shifts a LEN-bit word in
// LSB-first, counts the bits after which the core output was high and
// returns the count plus the final output on a valid/ready port.
// Optional macro SEQ_DETECT_SCHED_ABORT_EN adds an abort input and a
// resp_aborted output that cut a job short.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int LEN  = LEN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN-1:0]     req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [idw(NREQ)-1:0]    resp_id,
  output logic [hitw(LEN)-1:0]    resp_hits,
  output logic                    resp_final,
`ifdef SEQ_DETECT_SCHED_ABORT_EN
  input  logic                    abort,
  output logic                    resp_aborted,
`endif
  output logic                    busy
);

  localparam int IW = idw(NREQ);
  localparam int HW = hitw(LEN);
  localparam logic [HW-1:0] LAST_BIT = HW'(LEN - 1);

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   ptr;
  logic [LEN-1:0]  word;
  logic [HW-1:0]   bit_cnt;
  logic            core_clr;
  logic            core_en;
  logic            core_out;
  logic            abort_hit;
  logic            sample_hit;
  logic            enter_resp;

  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  logic [LEN-1:0]  grant_word;
  int              off;
  int              best_off;

  // Round-robin pick: the requester closest at or after the pointer wins
  always_comb begin
    grant_any  = |req;
    grant_idx  = '0;
    grant_word = '0;
    best_off   = NREQ;
    off        = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j]) begin
        off = (j + NREQ - int'(ptr)) % NREQ;
        if (off < best_off) begin
          best_off   = off;
          grant_idx  = IW'(j);
          grant_word = req_data[j*LEN +: LEN];
        end
      end
    end
  end

`ifdef SEQ_DETECT_SCHED_ABORT_EN
  assign abort_hit = abort && ((state == CLEAR) || (state == SHIFT) || (state == TAIL));
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state and core control for the job sequence
  always_comb begin
    state_next = state;
    core_clr   = 1'b0;
    core_en    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) state_next = CLEAR;
      end
      CLEAR: begin
        core_clr   = 1'b1;
        state_next = abort_hit ? RESP : SHIFT;
      end
      SHIFT: begin
        if (abort_hit) begin
          state_next = RESP;
        end else begin
          core_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_next = TAIL;
        end
      end
      TAIL: begin
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The core output reflects bit k one cycle after it is shifted, so the
  // first SHIFT cycle has nothing to count and TAIL catches the last bit.
  assign sample_hit = core_out && (((state == SHIFT) && (bit_cnt != '0)) || (state == TAIL));
  assign enter_resp = (state != RESP) && (state_next == RESP);

  assign ack        = ((state == IDLE) && grant_any && !reset) ? (NREQ'(1) << grant_idx) : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Job datapath: grant capture, serial word, bit index, hit count, final out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      word       <= '0;
      bit_cnt    <= '0;
      resp_id    <= '0;
      resp_hits  <= '0;
      resp_final <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            ptr     <= IW'((int'(grant_idx) + 1) % NREQ);
            word    <= grant_word;
            resp_id <= grant_idx;
          end
        end
        CLEAR: begin
          resp_hits <= '0;
          bit_cnt   <= '0;
        end
        SHIFT: begin
          if (core_en) begin
            word    <= word >> 1;
            bit_cnt <= bit_cnt + HW'(1);
          end
        end
        default: begin
        end
      endcase
      if (sample_hit) resp_hits <= resp_hits + HW'(1);
      if (enter_resp) resp_final <= core_out;
    end
  end

`ifdef SEQ_DETECT_SCHED_ABORT_EN
  // Tag each response as aborted or completed when it is formed
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           resp_aborted <= 1'b0;
    else if (enter_resp) resp_aborted <= abort_hit;
  end
`endif

  seq_detect_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (core_clr),
    .en    (core_en),
    .din   (word[0]),
    .out   (core_out)
  );

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched. A job-level model predicts
// grants and responses every cycle; directed scenarios add literal checks.
module tb_seq_detect_sched;
  import seq_detect_pkg::*;

  localparam int NREQ = 4;
  localparam int LEN  = 8;
  localparam int IW   = idw(NREQ);
  localparam int HW   = hitw(LEN);

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*LEN-1:0] req_data;
  logic [NREQ-1:0]     ack;
  logic                resp_valid;
  logic                resp_ready;
  logic [IW-1:0]       resp_id;
  logic [HW-1:0]       resp_hits;
  logic                resp_final;
  logic                busy;
`ifdef SEQ_DETECT_SCHED_ABORT_EN
  logic                abort;
  logic                resp_aborted;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model state
  bit             m_idle = 1'b1;
  int             m_t;
  int             m_ptr = 0;
  int             m_id;
  int             m_hits;
  bit             m_final;
  bit             m_aborted;
  logic [LEN-1:0] m_word;
  bit             m_valid_seen;
  int             g;
  logic [NREQ-1:0] exp_ack;
  bit             exp_valid;

  // observations for directed checks
  int n_resp = 0;
  int last_id, last_hits, last_ack_cyc, last_valid_cyc, last_xfer_cyc;
  bit last_final, last_aborted;
  int ack_idx_q[$];
  int ack_cyc_q[$];

  seq_detect_sched #(.NREQ(NREQ), .LEN(LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_hits    (resp_hits),
    .resp_final   (resp_final),
`ifdef SEQ_DETECT_SCHED_ABORT_EN
    .abort        (abort),
    .resp_aborted (resp_aborted),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Core as a 2-bit value v=2a+b: a 1 bit counts v up mod 4, a 0 bit only
  // moves 3 back to 1. Counts samples taken up to cycle upto_t of a job
  // (bit k is observed at cycle k+3 after the grant).
  function automatic void predictJob(input logic [LEN-1:0] w, input int upto_t,
                                     output int hits, output bit fin);
    int v;
    v    = 0;
    hits = 0;
    fin  = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      if (k + 3 <= upto_t) begin
        if (w[k]) v = (v + 1) % 4;
        else if (v == 3) v = 1;
        if (v == 3) hits++;
        fin = (v == 3);
      end
    end
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (reset) begin
      m_idle       = 1'b1;
      m_ptr        = 0;
      m_valid_seen = 1'b0;
    end else begin
      g = -1;
      if (m_idle) begin
        for (int i = 0; i < NREQ; i++) begin
          if (g < 0 && req[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
        end
      end
      exp_ack = '0;
      if (g >= 0) exp_ack[g] = 1'b1;
      exp_valid = !m_idle && (m_t >= LEN + 3);
      checkOutput("ack", 32'(ack), 32'(exp_ack));
      checkOutput("resp_valid", 32'(resp_valid), 32'(exp_valid));
      checkOutput("busy", 32'(busy), 32'(!m_idle));
      if (exp_valid) begin
        checkOutput("resp_id", 32'(resp_id), 32'(m_id));
        checkOutput("resp_hits", 32'(resp_hits), 32'(m_hits));
        checkOutput("resp_final", 32'(resp_final), 32'(m_final));
`ifdef SEQ_DETECT_SCHED_ABORT_EN
        checkOutput("resp_aborted", 32'(resp_aborted), 32'(m_aborted));
`endif
        if (!m_valid_seen) begin
          m_valid_seen   = 1'b1;
          last_valid_cyc = cyc;
        end
        if (resp_ready) begin
          n_resp++;
          last_id       = resp_id;
          last_hits     = resp_hits;
          last_final    = resp_final;
          last_xfer_cyc = cyc;
`ifdef SEQ_DETECT_SCHED_ABORT_EN
          last_aborted  = resp_aborted;
`endif
        end
      end
      if (m_idle) begin
        if (g >= 0) begin
          m_idle       = 1'b0;
          m_t          = 1;
          m_id         = g;
          m_word       = req_data[g*LEN +: LEN];
          predictJob(m_word, LEN + 2, m_hits, m_final);
          m_aborted    = 1'b0;
          m_ptr        = (g + 1) % NREQ;
          m_valid_seen = 1'b0;
          last_ack_cyc = cyc;
          ack_idx_q.push_back(g);
          ack_cyc_q.push_back(cyc);
        end
      end else if (exp_valid) begin
        if (resp_ready) m_idle = 1'b1;
      end else begin
`ifdef SEQ_DETECT_SCHED_ABORT_EN
        if (abort) begin
          predictJob(m_word, m_t, m_hits, m_final);
          m_aborted = 1'b1;
          m_t       = LEN + 3;
        end else
`endif
        m_t++;
      end
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] r, input int idx,
                               input logic [LEN-1:0] w, input logic rdy);
    req_data[idx*LEN +: LEN] = w;
    req        = r;
    resp_ready = rdy;
  endtask

  task automatic waitAck(input int idx);
    int n;
    n = 0;
    @(negedge clk);
    while (!ack[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ack_seen", 32'(ack[idx]), 32'(1));
    @(posedge clk);
    #1;
    req[idx] = 1'b0;
  endtask

  task automatic waitResp();
    int old;
    int n;
    old = n_resp;
    n   = 0;
    while (n_resp == old && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("resp_seen", 32'(n_resp != old), 32'(1));
  endtask

  initial begin
    int n;
    int old;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    reset      = 1'b1;
    req        = '0;
    req_data   = '0;
    resp_ready = 1'b1;
`ifdef SEQ_DETECT_SCHED_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ack", 32'(ack), 32'(0));
    checkOutput("reset_valid", 32'(resp_valid), 32'(0));
    checkOutput("reset_id", 32'(resp_id), 32'(0));
    checkOutput("reset_hits", 32'(resp_hits), 32'(0));
    checkOutput("reset_final", 32'(resp_final), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;

    $display("[TB] single jobs");
    applyStimulus(4'b0001, 0, 8'hFF, 1'b1);
    waitAck(0);
    waitResp();
    checkOutput("ff_id", 32'(last_id), 32'(0));
    checkOutput("ff_hits", 32'(last_hits), 32'(2));
    checkOutput("ff_final", 32'(last_final), 32'(0));
    checkOutput("ff_latency", 32'(last_valid_cyc - last_ack_cyc), 32'(11));

    applyStimulus(4'b0010, 1, 8'h07, 1'b1);
    waitAck(1);
    waitResp();
    checkOutput("07_id", 32'(last_id), 32'(1));
    checkOutput("07_hits", 32'(last_hits), 32'(1));
    checkOutput("07_final", 32'(last_final), 32'(0));

    applyStimulus(4'b0100, 2, 8'h00, 1'b1);
    waitAck(2);
    waitResp();
    checkOutput("00_id", 32'(last_id), 32'(2));
    checkOutput("00_hits", 32'(last_hits), 32'(0));
    checkOutput("00_final", 32'(last_final), 32'(0));

    $display("[TB] all requesters held");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ack_idx_q.delete();
    ack_cyc_q.delete();
    req_data = {8'h55, 8'h00, 8'h07, 8'hFF};
    req      = 4'b1111;
    n = 0;
    while (ack_idx_q.size() < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    req = '0;
    checkOutput("rr_ack_count", 32'(ack_idx_q.size() >= 5), 32'(1));
    waitResp();
    if (ack_idx_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) checkOutput("rr_order", 32'(ack_idx_q[i]), 32'(exp_order[i]));
      for (int i = 1; i < 5; i++) checkOutput("rr_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'(12));
    end
    checkOutput("rr_last_hits", 32'(last_hits), 32'(2));

    $display("[TB] response back-pressure");
    applyStimulus(4'b0010, 1, 8'hFF, 1'b0);
    waitAck(1);
    applyStimulus(4'b0100, 2, 8'h07, 1'b0);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(resp_valid), 32'(1));
      checkOutput("stall_id", 32'(resp_id), 32'(1));
      checkOutput("stall_hits", 32'(resp_hits), 32'(2));
      checkOutput("stall_final", 32'(resp_final), 32'(0));
      checkOutput("stall_busy", 32'(busy), 32'(1));
      checkOutput("stall_ack", 32'(ack), 32'(0));
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    waitAck(2);
    checkOutput("regrant_gap", 32'(last_ack_cyc - last_xfer_cyc), 32'(1));
    waitResp();
    checkOutput("stall2_id", 32'(last_id), 32'(2));
    checkOutput("stall2_hits", 32'(last_hits), 32'(1));

    $display("[TB] reset during shift");
    applyStimulus(4'b0001, 0, 8'hFF, 1'b1);
    waitAck(0);
    repeat (4) @(posedge clk);
    #1;
    req[1] = 1'b1;
    req[3] = 1'b1;
    old    = n_resp;
    reset  = 1'b1;
    #1;
    checkOutput("midrst_ack", 32'(ack), 32'(0));
    checkOutput("midrst_valid", 32'(resp_valid), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    checkOutput("midrst_hits", 32'(resp_hits), 32'(0));
    checkOutput("midrst_id", 32'(resp_id), 32'(0));
    checkOutput("midrst_final", 32'(resp_final), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_regrant", 32'(ack), 32'(4'b0010));
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    checkOutput("midrst_no_resp", 32'(n_resp), 32'(old));
    waitAck(3);
    waitResp();
    checkOutput("midrst_last_id", 32'(last_id), 32'(3));

`ifdef SEQ_DETECT_SCHED_ABORT_EN
    $display("[TB] abort during shift");
    applyStimulus(4'b0001, 0, 8'hFF, 1'b1);
    waitAck(0);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    waitResp();
    checkOutput("abort_flag", 32'(last_aborted), 32'(1));
    checkOutput("abort_hits", 32'(last_hits), 32'(1));
    checkOutput("abort_final", 32'(last_final), 32'(0));
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Shared-resource scheduler for the 2-bit T-flip-flop sequence-detector core (state a,b; out = a&b).
- Accepts LEN-bit words from NREQ requesters with round-robin arbitration.
- Per job: clears the core, shifts the word in serially LSB-first, counts detector hits, and returns hit count plus final out on a valid/ready response port.
- Sits between packet-side requesters and the single detector instance, so the core is never duplicated.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LEN, 8, bits per job word (1..32)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset
- req  in  NREQ  per-requester job request, level
- req_data  in  NREQ*LEN  job words; requester i uses bits [i*LEN +: LEN]
- ack  out  NREQ  one-cycle grant pulse, one-hot
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  clog2(NREQ)  requester index of the result
- resp_hits  out  clog2(LEN+1)  number of bits after which the core out was 1
- resp_final  out  1  core out after the last bit
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: FSM=IDLE, ack=0, resp_valid=0, resp_id=0, resp_hits=0, resp_final=0, busy=0, rr pointer=0, core state (a,b)=00.
- Reset asserted mid-job aborts the job with no response. Pending req lines are re-arbitrated from pointer 0.
- Core (sub-module), with en and synchronous clr:
  - b' = b^in
  - a' = a ^ ((b&in) | (a&b))
  - out = a&b
  - clr has priority over en.
  - Neither clr nor en asserted: hold.
- IDLE:
  - If any req: grant the first requester at or after the rr pointer (wrapping).
  - Pulse ack[g], latch req_data word and id, set pointer = g+1 mod NREQ, go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR: core clr=1, hit counter=0, go to SHIFT.
- SHIFT: LEN cycles. Cycle k drives core en=1, in=word[k]. After the last bit, go to TAIL.
- TAIL: one cycle, allowing the final sample to be counted, then go to RESP.
- Hit counting: for each k in 0..LEN-1, add 1 if out==1 in the state that follows bit k (sampled one cycle after en). Counter width is clog2(LEN+1); saturation cannot occur.
- RESP:
  - resp_valid=1; resp_id, resp_hits, resp_final held stable until resp_valid&resp_ready.
  - On that transfer cycle go to IDLE. resp_valid drops the next cycle.
  - No new grant in the transfer cycle.
- Latency: ack at cycle 0, resp_valid first high at cycle LEN+3. Throughput is one job per LEN+4 cycles with resp_ready tied high.
- Requester rules:
  - Hold req and data stable until ack.
  - Dropping req before ack is a legal withdrawal.
  - req still high the cycle after ack counts as a new job.
- Simultaneous req from all requesters: serviced in pointer order, so no starvation. Worst-case wait is (NREQ-1) jobs.
- req changes during a job have no effect until the next IDLE.

Optional Feature:
- Macro: SEQ_DETECT_SCHED_ABORT_EN.
- Defined:
  - Adds input abort(1) and output resp_aborted(1).
  - abort high in CLEAR, SHIFT or TAIL jumps directly to RESP with resp_aborted=1, resp_hits = hits counted so far, resp_final = current core out.
  - abort is ignored in IDLE and RESP.
  - resp_aborted=0 for normal completions; reset value 0.
- Undefined: neither port exists and every job completes.

Decomposition:
- Package seq_detect_pkg:
  - state enum {IDLE, CLEAR, SHIFT, TAIL, RESP}
  - width helpers idw(NREQ) and hitw(LEN)
  - default parameter constants
- Sub-module seq_detect_core: the two T-flip-flop state bits (a,b) with async reset, sync clr, en, in, and out.
- Arbiter and bit counter stay inline in the top.

Test Plan:
- Reset, then req[0], data=0xFF, LEN=8 -> ack[0] at cycle 0; resp at cycle 11 with id=0, hits=2, final=0 (states 01,10,11,00 repeating).
- req[1], data=0x07 -> hits=1, final=0 (states 01,10,11,01,01,...).
- req[2], data=0x00 -> hits=0, final=0; core stays at 00 throughout.
- req=4'b1111 held, resp_ready=1 -> ack order 0,1,2,3,0; ack spacing 12 cycles.
- resp_ready=0 for 5 cycles -> resp fields stable, no new ack, busy=1; then ready=1 -> IDLE next cycle, grant the following cycle.
- Reset pulse in SHIFT bit 3 -> all outputs zero immediately, no response. With ABORT_EN: abort during SHIFT bit 4 of 0xFF -> resp_aborted=1, hits=1.
